key_entry_reg: RTL and testbench

Keypad entry buffer that sits directly upstream of the alarm register. It collects BCD digit key presses into a four-digit HH:MM shift buffer and checks that the entry is a legal 24-hour time. On the ALARM key it issues a one-cycle `load_new_alarm` strobe with the entered digits held stable, and it abandons stale entries after an inactivity timeout. Its digit outputs connect straight to the alarm register's `new_alarm_*` inputs.

---
 rtl/key_entry_reg.sv | 180 ++++++++++++++++++
 tb/tb_key_entry_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_reg.sv
// ---------------------------------------------------------------------------
// key_entry_reg
// Keypad entry buffer feeding the alarm register. Collects BCD digit keys
// into a four-digit HH:MM shift buffer, checks the buffer is a legal 24-hour
// time, and on the ALARM key issues a one-cycle load_new_alarm strobe while
// the entered digits are held stable. Stale entries are abandoned after
// TIMEOUT_SEC one_second pulses with no key.
//
// Parameters
//   TIMEOUT_SEC      : one_second pulses without a key before abandon (1..255)
// Ports
//   clock            : in  1  rising-edge clock
//   reset            : in  1  synchronous, active-high
//   key_in           : in  4  0-9 digit, A ALARM, B CLEAR, C-F ignored
//   key_valid        : in  1  key_in sampled when high
//   one_second       : in  1  timebase tick
//   new_alarm_ms_hr  : out 4  hours tens digit
//   new_alarm_ls_hr  : out 4  hours units digit
//   new_alarm_ms_min : out 4  minutes tens digit
//   new_alarm_ls_min : out 4  minutes units digit
//   load_new_alarm   : out 1  one-cycle commit strobe
//   entry_active     : out 1  high in ENTRY or COMMIT
//   entry_error      : out 1  one-cycle pulse on rejected commit
//   entry_timeout    : out 1  one-cycle pulse on inactivity abandon
//   digit_count      : out 3  digits entered, saturates at 4
// ---------------------------------------------------------------------------
module key_entry_reg #(
   parameter int unsigned TIMEOUT_SEC = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] key_in,
   input  logic       key_valid,
   input  logic       one_second,
   output logic [3:0] new_alarm_ms_hr,
   output logic [3:0] new_alarm_ls_hr,
   output logic [3:0] new_alarm_ms_min,
   output logic [3:0] new_alarm_ls_min,
   output logic       load_new_alarm,
   output logic       entry_active,
   output logic       entry_error,
   output logic       entry_timeout,
   output logic [2:0] digit_count
);

   localparam logic [3:0] KEY_ALARM = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hB;
   localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_SEC);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENTRY  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t      state, state_nxt;
   // {ms_hr, ls_hr, ms_min, ls_min}
   logic [15:0] digits_q, digits_nxt;
   logic [2:0]  count_q, count_nxt;
   logic [7:0]  timer_q, timer_nxt;
   logic        load_nxt, error_nxt, timeout_nxt, active_nxt;
   logic        active_q;

   logic        is_digit;
   logic        legal;
   logic [8:0]  tick_sum;

   assign is_digit = (key_in <= 4'd9);

   assign legal = (digits_q[15:12] <= 4'd2) &&
                  !((digits_q[15:12] == 4'd2) && (digits_q[11:8] > 4'd3)) &&
                  (digits_q[7:4] <= 4'd5);

   // Nine bits so the compare against the limit never wraps.
   assign tick_sum = {1'b0, timer_q} + 9'd1;

   always_comb begin
      state_nxt   = state;
      digits_nxt  = digits_q;
      count_nxt   = count_q;
      timer_nxt   = timer_q;
      load_nxt    = 1'b0;
      error_nxt   = 1'b0;
      timeout_nxt = 1'b0;

      unique case (state)
         IDLE: begin
            timer_nxt = '0;
            if (key_valid && is_digit) begin
               state_nxt  = ENTRY;
               digits_nxt = {digits_q[11:0], key_in};
               count_nxt  = 3'd1;
            end
         end

         ENTRY: begin
            // A valid key always wins over a coincident tick; the tick is dropped.
            if (key_valid) begin
               if (is_digit) begin
                  digits_nxt = {digits_q[11:0], key_in};
                  count_nxt  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
                  timer_nxt  = '0;
               end else if (key_in == KEY_ALARM) begin
                  if (legal) begin
                     state_nxt = COMMIT;
                     load_nxt  = 1'b1;
                  end else begin
                     state_nxt  = IDLE;
                     digits_nxt = '0;
                     count_nxt  = '0;
                     timer_nxt  = '0;
                     error_nxt  = 1'b1;
                  end
               end else if (key_in == KEY_CLEAR) begin
                  state_nxt  = IDLE;
                  digits_nxt = '0;
                  count_nxt  = '0;
                  timer_nxt  = '0;
               end
            end else if (one_second) begin
               if (tick_sum == TIMEOUT_LIMIT) begin
                  state_nxt   = IDLE;
                  digits_nxt  = '0;
                  count_nxt   = '0;
                  timer_nxt   = '0;
                  timeout_nxt = 1'b1;
               end else begin
                  timer_nxt = tick_sum[7:0];
               end
            end
         end

         COMMIT: begin
            state_nxt  = IDLE;
            digits_nxt = '0;
            count_nxt  = '0;
            timer_nxt  = '0;
         end

         default: begin
            state_nxt  = IDLE;
            digits_nxt = '0;
            count_nxt  = '0;
            timer_nxt  = '0;
         end
      endcase

      active_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         digits_q       <= '0;
         count_q        <= '0;
         timer_q        <= '0;
         load_new_alarm <= 1'b0;
         entry_error    <= 1'b0;
         entry_timeout  <= 1'b0;
         active_q       <= 1'b0;
      end else begin
         state          <= state_nxt;
         digits_q       <= digits_nxt;
         count_q        <= count_nxt;
         timer_q        <= timer_nxt;
         load_new_alarm <= load_nxt;
         entry_error    <= error_nxt;
         entry_timeout  <= timeout_nxt;
         active_q       <= active_nxt;
      end
   end

   assign new_alarm_ms_hr  = digits_q[15:12];
   assign new_alarm_ls_hr  = digits_q[11:8];
   assign new_alarm_ms_min = digits_q[7:4];
   assign new_alarm_ls_min = digits_q[3:0];
   assign digit_count      = count_q;
   assign entry_active     = active_q;

endmodule

// File: tb/tb_key_entry_reg.sv
module tb_key_entry_reg;

   logic       clock;
   logic       reset;
   logic [3:0] key_in;
   logic       key_valid;
   logic       one_second;
   logic [3:0] new_alarm_ms_hr;
   logic [3:0] new_alarm_ls_hr;
   logic [3:0] new_alarm_ms_min;
   logic [3:0] new_alarm_ls_min;
   logic       load_new_alarm;
   logic       entry_active;
   logic       entry_error;
   logic       entry_timeout;
   logic [2:0] digit_count;

   typedef struct packed {
      logic [15:0] dig;
      logic        ld;
      logic        act;
      logic        err;
      logic        to;
      logic [2:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   key_entry_reg #(.TIMEOUT_SEC(3)) dut (
      .clock            (clock),
      .reset            (reset),
      .key_in           (key_in),
      .key_valid        (key_valid),
      .one_second       (one_second),
      .new_alarm_ms_hr  (new_alarm_ms_hr),
      .new_alarm_ls_hr  (new_alarm_ls_hr),
      .new_alarm_ms_min (new_alarm_ms_min),
      .new_alarm_ls_min (new_alarm_ls_min),
      .load_new_alarm   (load_new_alarm),
      .entry_active     (entry_active),
      .entry_error      (entry_error),
      .entry_timeout    (entry_timeout),
      .digit_count      (digit_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus; the expected outputs after the sampling edge
   // are queued and compared by the monitor on the following falling edge.
   task automatic t(input logic r, input logic kv, input logic [3:0] k, input logic os,
                    input logic [15:0] dig, input logic ld, input logic act,
                    input logic err, input logic to, input logic [2:0] cnt);
      exp_t e;
      @(negedge clock);
      reset      = r;
      key_valid  = kv;
      key_in     = k;
      one_second = os;
      @(posedge clock);
      #1;
      reset      = 1'b0;
      key_valid  = 1'b0;
      one_second = 1'b0;
      e.dig = dig; e.ld = ld; e.act = act; e.err = err; e.to = to; e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   // Shorthands: digit key, plain tick, idle cycle.
   task automatic kd(input logic [3:0] k, input logic [15:0] dig, input logic [2:0] cnt);
      t(1'b0, 1'b1, k, 1'b0, dig, 1'b0, 1'b1, 1'b0, 1'b0, cnt);
   endtask

   task automatic idle_zero();
      t(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
   endtask

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("digits", {16'h0, new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min},
               {16'h0, e.dig});
         check("load_new_alarm", {31'h0, load_new_alarm}, {31'h0, e.ld});
         check("entry_active",   {31'h0, entry_active},   {31'h0, e.act});
         check("entry_error",    {31'h0, entry_error},    {31'h0, e.err});
         check("entry_timeout",  {31'h0, entry_timeout},  {31'h0, e.to});
         check("digit_count",    {29'h0, digit_count},    {29'h0, e.cnt});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; key_valid = 1'b0; key_in = 4'h0; one_second = 1'b0;

      // Reset state
      t(1, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 3'd0);
      t(1, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 3'd0);

      // 06:45 commit
      kd(4'h0, 16'h0000, 3'd1);
      kd(4'h6, 16'h0006, 3'd2);
      kd(4'h4, 16'h0064, 3'd3);
      kd(4'h5, 16'h0645, 3'd4);
      t(0, 1, 4'hA, 0, 16'h0645, 1, 1, 0, 0, 3'd4);
      idle_zero();

      // Shift-out: 1,2,3,0,9 -> 23:09, commit
      kd(4'h1, 16'h0001, 3'd1);
      kd(4'h2, 16'h0012, 3'd2);
      kd(4'h3, 16'h0123, 3'd3);
      kd(4'h0, 16'h1230, 3'd4);
      kd(4'h9, 16'h2309, 3'd4);
      t(0, 1, 4'hA, 0, 16'h2309, 1, 1, 0, 0, 3'd4);
      idle_zero();

      // Illegal hours 24:00
      kd(4'h2, 16'h0002, 3'd1);
      kd(4'h4, 16'h0024, 3'd2);
      kd(4'h0, 16'h0240, 3'd3);
      kd(4'h0, 16'h2400, 3'd4);
      t(0, 1, 4'hA, 0, 16'h0000, 0, 0, 1, 0, 3'd0);
      idle_zero();

      // Illegal minutes 12:60
      kd(4'h1, 16'h0001, 3'd1);
      kd(4'h2, 16'h0012, 3'd2);
      kd(4'h6, 16'h0126, 3'd3);
      kd(4'h0, 16'h1260, 3'd4);
      t(0, 1, 4'hA, 0, 16'h0000, 0, 0, 1, 0, 3'd0);
      idle_zero();

      // Upper legal boundary 23:59
      kd(4'h2, 16'h0002, 3'd1);
      kd(4'h3, 16'h0023, 3'd2);
      kd(4'h5, 16'h0235, 3'd3);
      kd(4'h9, 16'h2359, 3'd4);
      t(0, 1, 4'hA, 0, 16'h2359, 1, 1, 0, 0, 3'd4);
      idle_zero();

      // Timeout after 3 ticks
      kd(4'h7, 16'h0007, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0007, 0, 1, 0, 0, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0007, 0, 1, 0, 0, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0000, 0, 0, 0, 1, 3'd0);
      idle_zero();

      // Digit after two ticks restarts the count
      kd(4'h7, 16'h0007, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0007, 0, 1, 0, 0, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0007, 0, 1, 0, 0, 3'd1);
      kd(4'h8, 16'h0078, 3'd2);
      t(0, 0, 4'h0, 1, 16'h0078, 0, 1, 0, 0, 3'd2);
      t(0, 0, 4'h0, 1, 16'h0078, 0, 1, 0, 0, 3'd2);
      t(0, 0, 4'h0, 1, 16'h0000, 0, 0, 0, 1, 3'd0);
      idle_zero();

      // Key with coincident tick: tick dropped, needs 3 more ticks
      t(0, 1, 4'h5, 1, 16'h0005, 0, 1, 0, 0, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0005, 0, 1, 0, 0, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0005, 0, 1, 0, 0, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0000, 0, 0, 0, 1, 3'd0);

      // CLEAR in ENTRY, ALARM/CLEAR/tick in IDLE
      kd(4'h3, 16'h0003, 3'd1);
      t(0, 1, 4'hB, 0, 16'h0000, 0, 0, 0, 0, 3'd0);
      t(0, 1, 4'hA, 0, 16'h0000, 0, 0, 0, 0, 3'd0);
      t(0, 1, 4'hB, 0, 16'h0000, 0, 0, 0, 0, 3'd0);
      t(0, 0, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 3'd0);

      // Ignored key code does not reset the timer
      kd(4'h1, 16'h0001, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0001, 0, 1, 0, 0, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0001, 0, 1, 0, 0, 3'd1);
      t(0, 1, 4'hC, 0, 16'h0001, 0, 1, 0, 0, 3'd1);
      t(0, 0, 4'h0, 1, 16'h0000, 0, 0, 0, 1, 3'd0);

      // Keys during COMMIT are ignored
      kd(4'h1, 16'h0001, 3'd1);
      kd(4'h2, 16'h0012, 3'd2);
      kd(4'h3, 16'h0123, 3'd3);
      kd(4'h0, 16'h1230, 3'd4);
      t(0, 1, 4'hA, 0, 16'h1230, 1, 1, 0, 0, 3'd4);
      t(0, 1, 4'h5, 0, 16'h0000, 0, 0, 0, 0, 3'd0);
      idle_zero();

      // Reset during COMMIT
      kd(4'h1, 16'h0001, 3'd1);
      kd(4'h2, 16'h0012, 3'd2);
      kd(4'h3, 16'h0123, 3'd3);
      kd(4'h0, 16'h1230, 3'd4);
      t(0, 1, 4'hA, 0, 16'h1230, 1, 1, 0, 0, 3'd4);
      t(1, 1, 4'h9, 0, 16'h0000, 0, 0, 0, 0, 3'd0);
      idle_zero();
      idle_zero();

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clock);
      @(negedge clock);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
